// File: rtl/cntr8_cmd.sv
// Command sequencer for an external 8-bit up/down/load counter.
// Optional SEEK timeout (256 cycles, err pulse) enabled by CNTR8_CMD_TIMEOUT_EN.
module cntr8_cmd (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] arg,
    input  logic [7:0] cnt_q,
    output logic       load,
    output logic       inc,
    output logic [7:0] d_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_SEEK = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     state;
    logic [1:0] op_r;
    logic [7:0] arg_r;
    logic [7:0] step;

`ifdef CNTR8_CMD_TIMEOUT_EN
    logic [7:0] tmo;
    logic       err_r;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op_r  <= 2'd0;
            arg_r <= 8'd0;
            step  <= 8'd0;
`ifdef CNTR8_CMD_TIMEOUT_EN
            tmo   <= 8'd0;
            err_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        arg_r <= arg;
                        step  <= arg;
`ifdef CNTR8_CMD_TIMEOUT_EN
                        tmo   <= 8'd0;
                        err_r <= 1'b0;
`endif
                        case (op)
                            2'b00:   state <= S_LOAD;
                            2'b01:   state <= S_UP;
                            2'b10:   state <= S_DOWN;
                            default: state <= S_SEEK;
                        endcase
                    end
                end
                S_LOAD: state <= S_DONE;
                S_UP, S_DOWN: begin
                    // step==0 means a zero-length command: one hold cycle
                    if (step != 8'd0) step <= step - 8'd1;
                    if (step <= 8'd1) state <= S_DONE;
                end
                S_SEEK: begin
                    if (cnt_q == arg_r) begin
                        state <= S_DONE;
                    end
`ifdef CNTR8_CMD_TIMEOUT_EN
                    else begin
                        tmo <= tmo + 8'd1;
                        if (tmo == 8'hFF) begin
                            state <= S_DONE;
                            err_r <= 1'b1;
                        end
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        load = 1'b1;
        inc  = 1'b0;
        d_in = cnt_q;
        case (state)
            S_LOAD: d_in = arg_r;
            S_UP, S_DOWN: begin
                if (step != 8'd0) begin
                    load = 1'b0;
                    inc  = (op_r == 2'b01);
                end
            end
            S_SEEK: begin
                if (cnt_q < arg_r) begin
                    load = 1'b0;
                    inc  = 1'b1;
                end else if (cnt_q > arg_r) begin
                    load = 1'b0;
                end else begin
                    d_in = arg_r;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign o_state = state;

`ifdef CNTR8_CMD_TIMEOUT_EN
    assign err = done & err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cntr8_cmd.sv
// Self-checking bench for cntr8_cmd with an attached behavioural counter.
// Directed, random, reset-abort and (optional) timeout scenarios.
module tb_cntr8_cmd;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'd0;
    logic [7:0] arg = 8'd0;
    logic [7:0] cnt_q;
    logic       load, inc, busy, done, err;
    logic [7:0] d_in;
    logic [2:0] o_state;

    logic       cnt_clr = 1'b1;
    logic       cnt_zero = 1'b0;
    logic [7:0] mdl = 8'd0;

    int n_cmp = 0;
    int n_err = 0;

    cntr8_cmd dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .arg     (arg),
        .cnt_q   (cnt_q),
        .load    (load),
        .inc     (inc),
        .d_in    (d_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    // External counter driven by the sequencer
    always @(posedge clk) begin
        if (cnt_clr || cnt_zero) cnt_q <= 8'd0;
        else if (load)           cnt_q <= d_in;
        else if (inc)            cnt_q <= cnt_q + 8'd1;
        else                     cnt_q <= cnt_q - 8'd1;
    end

    // Command-level reference: cycles spent in the op state, step counts, result
    function automatic void ref_cmd(input logic [1:0] o, input logic [7:0] a,
                                    input logic [7:0] cur, output int st,
                                    output int up, output int dn,
                                    output logic [7:0] nxt);
        int c = cur;
        int t = a;
        st = 1; up = 0; dn = 0; nxt = cur;
        case (o)
            2'b00: nxt = a;
            2'b01: begin
                up = t; st = (t == 0) ? 1 : t;
                nxt = 8'((c + t) % 256);
            end
            2'b10: begin
                dn = t; st = (t == 0) ? 1 : t;
                nxt = 8'((c - t + 256) % 256);
            end
            default: begin
                if (t > c) up = t - c;
                else       dn = c - t;
                st = up + dn + 1;
                nxt = a;
            end
        endcase
    endfunction

    // Issue one command; random start pulses while busy must be ignored
    task automatic run_cmd(input logic [1:0] c_op, input logic [7:0] c_arg,
                           output int n_st, output int n_up, output int n_dn,
                           output int n_bad, output logic got_done,
                           output logic err_v);
        logic [2:0] code;
        code = {1'b0, c_op} + 3'd1;
        n_st = 0; n_up = 0; n_dn = 0; n_bad = 0;
        got_done = 1'b0; err_v = 1'b0;
        @(negedge clk);
        start = 1'b1; op = c_op; arg = c_arg;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (o_state == 3'd5) begin
                got_done = done; err_v = err; start = 1'b0;
                break;
            end
            if (o_state != code || done || !busy) n_bad++;
            n_st++;
            if (!load) begin
                if (inc) n_up++;
                else     n_dn++;
            end
            start = 1'($urandom);
            op    = 2'($urandom);
            arg   = 8'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cnt_clr = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1; cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cnt_q !== 8'h00 || load !== 1'b1 || busy !== 1'b0 ||
                o_state !== 3'd0 || done !== 1'b0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: cnt=%h load=%b busy=%b st=%0d done=%b err=%b, need 00 1 0 0 0 0",
                         i, cnt_q, load, busy, o_state, done, err);
            end
        end
        mdl = 8'h00;
    endtask

    task automatic test_load;
        int st, up, dn, bad;
        logic gd, ev;
        run_cmd(2'b00, 8'hFA, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || st != 1 || bad != 0 || ev !== 1'b0) begin
            n_err++;
            $display("FAIL load_seq: done=%b cycles=%0d bad=%0d err=%b, need 1 1 0 0", gd, st, bad, ev);
        end
        @(negedge clk);
        n_cmp++;
        if (cnt_q !== 8'hFA || o_state !== 3'd0 || done !== 1'b0 || load !== 1'b1) begin
            n_err++;
            $display("FAIL load_hold: cnt=%h st=%0d done=%b load=%b, need FA 0 0 1", cnt_q, o_state, done, load);
        end
        mdl = 8'hFA;
    endtask

    task automatic test_up_down;
        int st, up, dn, bad;
        logic gd, ev;
        run_cmd(2'b01, 8'h08, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || up != 8 || dn != 0 || st != 8 || bad != 0 || cnt_q !== 8'h02) begin
            n_err++;
            $display("FAIL up_wrap: done=%b up=%0d dn=%0d cyc=%0d bad=%0d cnt=%h, need 1 8 0 8 0 02",
                     gd, up, dn, st, bad, cnt_q);
        end
        run_cmd(2'b10, 8'h03, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || dn != 3 || up != 0 || bad != 0 || cnt_q !== 8'hFF) begin
            n_err++;
            $display("FAIL down: done=%b dn=%0d up=%0d bad=%0d cnt=%h, need 1 3 0 0 FF", gd, dn, up, bad, cnt_q);
        end
        run_cmd(2'b01, 8'h00, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || st != 1 || up != 0 || dn != 0 || cnt_q !== 8'hFF) begin
            n_err++;
            $display("FAIL up_zero: done=%b cyc=%0d up=%0d dn=%0d cnt=%h, need 1 1 0 0 FF", gd, st, up, dn, cnt_q);
        end
        mdl = 8'hFF;
    endtask

    task automatic test_seek;
        int st, up, dn, bad;
        logic gd, ev;
        run_cmd(2'b00, 8'h10, st, up, dn, bad, gd, ev);
        run_cmd(2'b11, 8'h0C, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || dn != 4 || up != 0 || st != 5 || bad != 0 || cnt_q !== 8'h0C || ev !== 1'b0) begin
            n_err++;
            $display("FAIL seek_down: done=%b dn=%0d up=%0d cyc=%0d bad=%0d cnt=%h err=%b, need 1 4 0 5 0 0C 0",
                     gd, dn, up, st, bad, cnt_q, ev);
        end
        run_cmd(2'b11, 8'h0C, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || st != 1 || up != 0 || dn != 0 || cnt_q !== 8'h0C) begin
            n_err++;
            $display("FAIL seek_equal: done=%b cyc=%0d up=%0d dn=%0d cnt=%h, need 1 1 0 0 0C", gd, st, up, dn, cnt_q);
        end
        mdl = 8'h0C;
    endtask

    task automatic test_random;
        int st, up, dn, bad, e_st, e_up, e_dn;
        logic gd, ev;
        logic [1:0] o;
        logic [7:0] a, nxt;
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom);
            a = 8'($urandom);
            if (o != 2'b11 && (k % 4) == 0) a = 8'($urandom_range(0, 3));
            ref_cmd(o, a, mdl, e_st, e_up, e_dn, nxt);
            run_cmd(o, a, st, up, dn, bad, gd, ev);
            n_cmp++;
            if (gd !== 1'b1 || ev !== 1'b0 || st != e_st || up != e_up || dn != e_dn ||
                bad != 0 || cnt_q !== nxt || o_state !== 3'd0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d op=%0d arg=%h from=%h: done=%b err=%b cyc=%0d up=%0d dn=%0d bad=%0d cnt=%h st=%0d, need 1 0 %0d %0d %0d 0 %h 0",
                         k, o, a, mdl, gd, ev, st, up, dn, bad, cnt_q, o_state, e_st, e_up, e_dn, nxt);
            end
            mdl = nxt;
        end
    endtask

    task automatic test_reset_abort;
        int st, up, dn, bad, k;
        logic gd, ev;
        logic seen_done;
        run_cmd(2'b00, 8'h20, st, up, dn, bad, gd, ev);
        @(negedge clk);
        start = 1'b1; op = 2'b01; arg = 8'h05;
        k = 0;
        for (int i = 0; i < 10 && k < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!load && inc) k++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (k != 2 || o_state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || cnt_q !== 8'h22) begin
            n_err++;
            $display("FAIL abort_reset: steps=%0d st=%0d busy=%b done=%b cnt=%h, need 2 0 0 0 22",
                     k, o_state, busy, done, cnt_q);
        end
        reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done || cnt_q !== 8'h22 || o_state !== 3'd0) begin
            n_err++;
            $display("FAIL abort_hold: done_seen=%b cnt=%h st=%0d, need 0 22 0", seen_done, cnt_q, o_state);
        end
        mdl = 8'h22;
    endtask

`ifdef CNTR8_CMD_TIMEOUT_EN
    task automatic test_timeout;
        int st, up, dn, bad;
        logic gd, ev;
        run_cmd(2'b00, 8'h00, st, up, dn, bad, gd, ev);
        cnt_zero = 1'b1;
        run_cmd(2'b11, 8'h80, st, up, dn, bad, gd, ev);
        n_cmp++;
        if (gd !== 1'b1 || ev !== 1'b1 || st != 256 || up != 256 || bad != 0) begin
            n_err++;
            $display("FAIL seek_timeout: done=%b err=%b cyc=%0d up=%0d bad=%0d, need 1 1 256 256 0",
                     gd, ev, st, up, bad);
        end
        n_cmp++;
        if (err !== 1'b0 || o_state !== 3'd0) begin
            n_err++;
            $display("FAIL timeout_pulse: err=%b st=%0d, need 0 0", err, o_state);
        end
        cnt_zero = 1'b0;
        mdl = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_up_down();
        test_seek();
        test_random();
        test_reset_abort();
`ifdef CNTR8_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
